// File: rtl/cordic_nco_if.sv
// Configuration handshake bundle for cordic_nco: one word carries the frequency,
// phase offset and amplitude, offered with valid and accepted with ready.
interface cordic_nco_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [ACC_WIDTH-1:0] cfg_freq;
    logic [WIDTH-1:0]     cfg_phase;
    logic [WIDTH-1:0]     cfg_amp;

    modport master (output cfg_valid, output cfg_freq, output cfg_phase, output cfg_amp,
                    input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_freq, input  cfg_phase, input  cfg_amp,
                    output cfg_ready);
endinterface

// File: rtl/cordic_nco.sv
// Phase-accumulator NCO front end producing x0/y0/z0 for a rotating-mode CORDIC,
// with phase-continuous config updates at the accumulator wrap and a valid delay line.
module cordic_nco #(
    parameter int WIDTH      = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ITERATIONS = WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    cordic_nco_if.slave      cfg,
    output logic [WIDTH-1:0] x0,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] z0,
    output logic             sample_valid,
    output logic             cordic_valid
);
    typedef enum logic {GEN_IDLE = 1'b0, GEN_RUN = 1'b1} gen_state_t;
    typedef enum logic {CFG_EMPTY = 1'b0, CFG_PENDING = 1'b1} cfg_state_t;

    gen_state_t           gen_state_r;
    cfg_state_t           cfg_state_r;
    logic                 cfg_ready_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] freq_r;
    logic [WIDTH-1:0]     phase_r;
    logic [WIDTH-1:0]     amp_r;
    logic [ACC_WIDTH-1:0] shadow_freq_r;
    logic [WIDTH-1:0]     shadow_phase_r;
    logic [WIDTH-1:0]     shadow_amp_r;
    logic [WIDTH-1:0]     x0_r;
    logic [WIDTH-1:0]     y0_r;
    logic [WIDTH-1:0]     z0_r;
    logic [ITERATIONS:0]  valid_dly_r;

    logic [ACC_WIDTH:0]   sum_s;
    logic                 wrap_s;
    logic                 pending_s;
    logic                 transfer_s;
    logic                 apply_s;

    // The carry out of the extended sum marks the accumulator wrap, the only
    // running point where a new frequency/phase can enter without a phase jump.
    assign sum_s      = {1'b0, acc_r} + {1'b0, freq_r};
    assign wrap_s     = enable && sum_s[ACC_WIDTH];
    assign pending_s  = (cfg_state_r == CFG_PENDING);
    assign transfer_s = cfg.cfg_valid && cfg_ready_r;
    assign apply_s    = pending_s && (!enable || wrap_s || sync);

    // Generator: advances the accumulator and registers one CORDIC input sample per enabled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_state_r <= GEN_IDLE;
            acc_r       <= {ACC_WIDTH{1'b0}};
            x0_r        <= {WIDTH{1'b0}};
            y0_r        <= {WIDTH{1'b0}};
            z0_r        <= {WIDTH{1'b0}};
        end else begin
            case (gen_state_r)
                GEN_IDLE, GEN_RUN: begin
                    if (sync) begin
                        acc_r       <= {ACC_WIDTH{1'b0}};
                        gen_state_r <= GEN_IDLE;
                    end else if (enable) begin
                        acc_r       <= sum_s[ACC_WIDTH-1:0];
                        z0_r        <= acc_r[ACC_WIDTH-1 -: WIDTH] + phase_r;
                        x0_r        <= amp_r;
                        y0_r        <= {WIDTH{1'b0}};
                        gen_state_r <= GEN_RUN;
                    end else begin
                        gen_state_r <= GEN_IDLE;
                    end
                end
                default: begin
                    acc_r       <= {ACC_WIDTH{1'b0}};
                    gen_state_r <= GEN_IDLE;
                end
            endcase
        end
    end

    // Config: captures an offered word into the shadow and copies it to the active set at an apply point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_state_r    <= CFG_EMPTY;
            cfg_ready_r    <= 1'b1;
            freq_r         <= {ACC_WIDTH{1'b0}};
            phase_r        <= {WIDTH{1'b0}};
            amp_r          <= {WIDTH{1'b0}};
            shadow_freq_r  <= {ACC_WIDTH{1'b0}};
            shadow_phase_r <= {WIDTH{1'b0}};
            shadow_amp_r   <= {WIDTH{1'b0}};
        end else begin
            case (cfg_state_r)
                CFG_EMPTY: begin
                    if (transfer_s) begin
                        shadow_freq_r  <= cfg.cfg_freq;
                        shadow_phase_r <= cfg.cfg_phase;
                        shadow_amp_r   <= cfg.cfg_amp;
                        cfg_state_r    <= CFG_PENDING;
                        cfg_ready_r    <= 1'b0;
                    end else begin
                        cfg_ready_r    <= 1'b1;
                    end
                end
                CFG_PENDING: begin
                    if (apply_s) begin
                        freq_r      <= shadow_freq_r;
                        phase_r     <= shadow_phase_r;
                        amp_r       <= shadow_amp_r;
                        cfg_state_r <= CFG_EMPTY;
                        cfg_ready_r <= 1'b1;
                    end else begin
                        cfg_ready_r <= 1'b0;
                    end
                end
                default: begin
                    cfg_state_r <= CFG_EMPTY;
                    cfg_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Valid delay line matching the CORDIC input register, pipeline stages and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_dly_r <= {(ITERATIONS+1){1'b0}};
        end else begin
            valid_dly_r <= {valid_dly_r[ITERATIONS-1:0], sample_valid};
        end
    end

    assign x0            = x0_r;
    assign y0            = y0_r;
    assign z0            = z0_r;
    assign sample_valid  = (gen_state_r == GEN_RUN);
    assign cordic_valid  = valid_dly_r[ITERATIONS];
    assign cfg.cfg_ready = cfg_ready_r;
endmodule

// File: doc/cordic_nco.md
Name: cordic_nco

Overview:
Phase-accumulator front end that feeds the pipelined polar CORDIC running in rotating mode. It generates the CORDIC inputs x0, y0 and z0 every enabled cycle, so the CORDIC produces a quadrature sinusoid (cos on x, sin on y, scaled by K).
It accepts frequency, phase-offset and amplitude updates through a valid/ready handshake. Updates are applied phase-continuously at the accumulator wrap.
It also delays the sample-valid strobe so that it lines up with the CORDIC outputs.

Parameters:
WIDTH, 16, CORDIC data width; z0 full scale 2**WIDTH = 2π (π = 2**(WIDTH-1), π/2 = 2**(WIDTH-2))
ACC_WIDTH, 32, phase accumulator width; must be >= WIDTH
ITERATIONS, WIDTH+1, CORDIC iteration count; sets the valid delay

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
enable  in  1  advance accumulator / emit one sample this cycle
sync  in  1  clear accumulator, apply any pending config immediately
cfg_valid  in  1  config word offered
cfg_ready  out  1  config can be accepted
cfg_freq  in  ACC_WIDTH  phase increment per sample (unsigned)
cfg_phase  in  WIDTH  phase offset added to z0 (two's complement, mod 2π)
cfg_amp  in  WIDTH  amplitude driven on x0 (signed, must be >= 0)
x0  out  WIDTH  CORDIC x input
y0  out  WIDTH  CORDIC y input
z0  out  WIDTH  CORDIC z input (angle)
sample_valid  out  1  x0/y0/z0 hold a new sample
cordic_valid  out  1  sample_valid delayed to align with the CORDIC x/y/z outputs

Behaviour:
- Reset (reset_n low, asynchronous):
  - acc, active freq/phase/amp, shadow regs, x0, y0, z0 = 0
  - sample_valid = 0, valid delay line = 0, cordic_valid = 0
  - pending = 0, so cfg_ready = 1 once reset is released
- Reset mid-operation: discards the pending config and flushes the delay line; no valid pulse survives reset.
- Config handshake:
  - cfg_ready = !pending.
  - Transfer occurs when cfg_valid && cfg_ready. On that edge, shadow <= {cfg_freq, cfg_phase, cfg_amp} and pending <= 1.
  - The inputs are don't-care when there is no transfer.
  - pending clears on the edge where the shadow is applied. cfg_ready rises the following cycle; no combinational ready path.
- Apply points: the shadow is copied to the active registers on an edge where pending = 1 and one of the following holds:
  - (a) enable = 0 (generator idle), or
  - (b) enable = 1 and acc + freq carries out of bit ACC_WIDTH-1 (wrap), or
  - (c) sync = 1.
  - A transfer accepted on a wrap edge is NOT applied on that edge; it waits for the next apply point.
- Accumulator, on an enable = 1 edge:
  - acc <= acc + freq, modulo 2**ACC_WIDTH, using the active freq valid before that edge.
  - On a wrap edge with an apply, the new freq is used from the next edge on.
- Sample output, same edge:
  - z0 <= acc[ACC_WIDTH-1 -: WIDTH] + phase, using the pre-update acc, truncated and wrapping mod 2**WIDTH
  - x0 <= amp
  - y0 <= 0
  - sample_valid <= 1
- Latency: the new sample appears on the outputs 1 clock after the enable edge.
- enable = 0 edge: sample_valid <= 0; acc, x0, y0 and z0 hold.
- sync = 1 edge:
  - acc <= 0 and sample_valid <= 0, regardless of enable; sync has priority over enable.
  - The next enabled sample has z0 = phase.
- Valid delay: cordic_valid = sample_valid delayed ITERATIONS+1 cycles through a shift register (CORDIC latency: input reg + ITERATIONS-1 stages + output reg).
- State encoding: generator states IDLE (no sample last cycle), RUN (sample_valid = 1); config states EMPTY (pending = 0), PENDING (pending = 1).
  - IDLE -> RUN on enable && !sync
  - RUN -> IDLE on !enable || sync
  - EMPTY -> PENDING on transfer
  - PENDING -> EMPTY at an apply point

Test Plan:
WIDTH=16, ACC_WIDTH=32, ITERATIONS=17 throughout.
1. Reset, then cfg {freq=0x4000_0000, phase=0, amp=0x4000} with enable=0 -> applied on the next edge, cfg_ready back to 1 the cycle after; then enable=1 -> z0 = 0x0000, 0x4000, 0x8000, 0xC000, 0x0000 repeating, x0 = 0x4000, y0 = 0.
2. Valid alignment: a single-cycle enable pulse after reset -> sample_valid high 1 cycle later for 1 cycle; cordic_valid high exactly 18 cycles after sample_valid.
3. Phase-continuous update: running at freq=0x4000_0000; accept freq=0x2000_0000 mid-period -> cfg_ready held 0, old step continues until the acc wraps, then z0 steps by 0x2000; no phase discontinuity.
4. Simultaneous events: cfg transfer on the same edge as a wrap -> not applied until the next wrap; a second cfg_valid while pending -> cfg_ready = 0, no transfer.
5. sync with pending config (phase=0x1000) while enable=1 -> next sample_valid deasserts for one cycle; next sample z0 = 0x1000, with the new freq used for the step after.
6. reset_n pulsed low mid-run with pending config and a valid in flight -> all outputs 0 immediately; cordic_valid never pulses afterwards; cfg_ready = 1.
